// File: rtl/pma_region_cfg.sv
// ---------------------------------------------------------------------------
// pma_region_cfg
//
// Runtime-programmable physical-memory-attribute region table. It holds
// NrRules entries, each made of a base address, a length and a 4-bit
// attribute {lock, exec, cached, nonidem}. The entries load from parameters
// at reset. They can be rewritten and locked through a request/grant
// register port. A one-cycle pipelined lookup port reports which attributes
// apply to a physical address.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous reset, active-low
//   cfg_req_i        config access request (always granted)
//   cfg_we_i         1 = write, 0 = read
//   cfg_addr_i       {rule_idx, field[1:0]}; field 0 base, 1 length,
//                    2 attr, 3 reserved
//   cfg_wdata_i      write data (attr uses bits [3:0])
//   cfg_gnt_o        grant, combinational copy of cfg_req_i
//   cfg_rvalid_o     response valid, one cycle after grant
//   cfg_rdata_o      read data, zero on error or write
//   cfg_err_o        response error, valid with cfg_rvalid_o
//   cfg_epoch_o      number of successful writes, wrapping
//   lookup_valid_i   lookup request
//   lookup_addr_i    physical address to look up
//   res_valid_o      lookup result valid, one cycle after the request
//   res_hit_o        address matched at least one enabled rule
//   res_exec_o       OR of exec over matching rules
//   res_cached_o     OR of cached over matching rules
//   res_nonidem_o    OR of nonidem over matching rules
// ---------------------------------------------------------------------------
module pma_region_cfg #(
    parameter int unsigned NrRules    = 4,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned EpochWidth = 8,
    parameter logic [NrRules*AddrWidth-1:0] RstBase   = '0,
    parameter logic [NrRules*AddrWidth-1:0] RstLength = '0,
    parameter logic [NrRules*4-1:0]         RstAttr   = '0,
    localparam int unsigned CfgAddrWidth = $clog2(NrRules) + 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    cfg_req_i,
    input  logic                    cfg_we_i,
    input  logic [CfgAddrWidth-1:0] cfg_addr_i,
    input  logic [AddrWidth-1:0]    cfg_wdata_i,
    output logic                    cfg_gnt_o,
    output logic                    cfg_rvalid_o,
    output logic [AddrWidth-1:0]    cfg_rdata_o,
    output logic                    cfg_err_o,
    output logic [EpochWidth-1:0]   cfg_epoch_o,

    input  logic                    lookup_valid_i,
    input  logic [AddrWidth-1:0]    lookup_addr_i,
    output logic                    res_valid_o,
    output logic                    res_hit_o,
    output logic                    res_exec_o,
    output logic                    res_cached_o,
    output logic                    res_nonidem_o
);

    // Attribute bit positions inside each 4-bit entry.
    localparam int unsigned LockBit    = 3;
    localparam int unsigned ExecBit    = 2;
    localparam int unsigned CachedBit  = 1;
    localparam int unsigned NonidemBit = 0;

    localparam logic [1:0] FieldBase   = 2'd0;
    localparam logic [1:0] FieldLength = 2'd1;
    localparam logic [1:0] FieldAttr   = 2'd2;

    // -----------------------------------------------------------------------
    // Region table state
    // -----------------------------------------------------------------------
    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    logic [3:0]           attr_q [NrRules];

    // -----------------------------------------------------------------------
    // Config port decode
    // -----------------------------------------------------------------------
    // Shifting instead of slicing keeps the decode legal when NrRules = 1,
    // where the rule index field has zero width.
    logic [CfgAddrWidth-1:0] rule_idx;
    logic [1:0]              field;
    logic                    sel_valid;
    logic [AddrWidth-1:0]    sel_base;
    logic [AddrWidth-1:0]    sel_len;
    logic [3:0]              sel_attr;
    logic                    access_err;
    logic                    write_ok;
    logic [AddrWidth-1:0]    read_data;

    assign rule_idx  = cfg_addr_i >> 2;
    assign field     = cfg_addr_i[1:0];
    assign cfg_gnt_o = cfg_req_i;

    // The entry is selected by a comparison loop, not by direct indexing.
    // An index past the table therefore selects nothing and cannot read
    // outside the arrays.
    always_comb begin
        sel_valid = 1'b0;
        sel_base  = '0;
        sel_len   = '0;
        sel_attr  = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (32'(rule_idx) == i) begin
                sel_valid = 1'b1;
                sel_base  = base_q[i];
                sel_len   = len_q[i];
                sel_attr  = attr_q[i];
            end
        end
    end

    // Reads of a locked rule are legal. Only writes are refused.
    always_comb begin
        access_err = !sel_valid || (field == 2'd3) ||
                     (cfg_we_i && sel_attr[LockBit]);
        write_ok   = cfg_req_i && cfg_we_i && !access_err;
    end

    always_comb begin
        read_data = '0;
        case (field)
            FieldBase:   read_data = sel_base;
            FieldLength: read_data = sel_len;
            FieldAttr:   read_data = {{(AddrWidth-4){1'b0}}, sel_attr};
            default:     read_data = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Table update
    // -----------------------------------------------------------------------
    // A write succeeds only on an unlocked rule, so writing the whole
    // attribute nibble can set lock but can never clear it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
                len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
                attr_q[i] <= RstAttr[i*4 +: 4];
            end
        end else if (write_ok) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                if (32'(rule_idx) == i) begin
                    case (field)
                        FieldBase:   base_q[i] <= cfg_wdata_i;
                        FieldLength: len_q[i]  <= cfg_wdata_i;
                        FieldAttr:   attr_q[i] <= cfg_wdata_i[3:0];
                        default:     ;
                    endcase
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Config response and epoch
    // -----------------------------------------------------------------------
    logic                  rvalid_q;
    logic                  err_q;
    logic [AddrWidth-1:0]  rdata_q;
    logic [EpochWidth-1:0] epoch_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            epoch_q  <= '0;
        end else begin
            rvalid_q <= cfg_req_i;
            err_q    <= cfg_req_i && access_err;
            rdata_q  <= (cfg_req_i && !cfg_we_i && !access_err) ? read_data : '0;
            if (write_ok) begin
                epoch_q <= epoch_q + EpochWidth'(1);
            end
        end
    end

    assign cfg_rvalid_o = rvalid_q;
    assign cfg_err_o    = err_q;
    assign cfg_rdata_o  = rdata_q;
    assign cfg_epoch_o  = epoch_q;

    // -----------------------------------------------------------------------
    // Lookup match
    // -----------------------------------------------------------------------
    // The end address uses one extra bit so that a region ending at the top
    // of the address space does not wrap to zero. The match uses the table
    // as it stands before this cycle's write.
    logic [AddrWidth:0]   end_addr [NrRules];
    logic [NrRules-1:0]   match;
    logic                 hit_d;
    logic                 exec_d;
    logic                 cached_d;
    logic                 nonidem_d;

    always_comb begin
        hit_d     = 1'b0;
        exec_d    = 1'b0;
        cached_d  = 1'b0;
        nonidem_d = 1'b0;
        match     = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            end_addr[i] = {1'b0, base_q[i]} + {1'b0, len_q[i]};
            match[i]    = (len_q[i] != '0) &&
                          (lookup_addr_i >= base_q[i]) &&
                          ({1'b0, lookup_addr_i} < end_addr[i]);
            hit_d     = hit_d     | match[i];
            exec_d    = exec_d    | (match[i] & attr_q[i][ExecBit]);
            cached_d  = cached_d  | (match[i] & attr_q[i][CachedBit]);
            nonidem_d = nonidem_d | (match[i] & attr_q[i][NonidemBit]);
        end
    end

    // Result registers hold their value between requests. Only the valid
    // flag follows every cycle.
    logic res_valid_q;
    logic res_hit_q;
    logic res_exec_q;
    logic res_cached_q;
    logic res_nonidem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q   <= 1'b0;
            res_hit_q     <= 1'b0;
            res_exec_q    <= 1'b0;
            res_cached_q  <= 1'b0;
            res_nonidem_q <= 1'b0;
        end else begin
            res_valid_q <= lookup_valid_i;
            if (lookup_valid_i) begin
                res_hit_q     <= hit_d;
                res_exec_q    <= exec_d;
                res_cached_q  <= cached_d;
                res_nonidem_q <= nonidem_d;
            end
        end
    end

    assign res_valid_o   = res_valid_q;
    assign res_hit_o     = res_hit_q;
    assign res_exec_o    = res_exec_q;
    assign res_cached_o  = res_cached_q;
    assign res_nonidem_o = res_nonidem_q;

endmodule

// File: tb/tb_pma_region_cfg.sv
// ---------------------------------------------------------------------------
// tb_pma_region_cfg
//
// Directed bench for pma_region_cfg. The main instance has four rules and
// rule 0 preset to 0x8000_0000 + 0x4000_0000 with exec|cached. A second
// instance with three rules exercises an out-of-range rule index, which the
// four-rule address field cannot encode.
// ---------------------------------------------------------------------------
module tb_pma_region_cfg;

    localparam int unsigned NR  = 4;
    localparam int unsigned AW  = 64;
    localparam int unsigned EW  = 8;
    localparam int unsigned CAW = $clog2(NR) + 2;

    localparam logic [NR*AW-1:0] RST_BASE   = {64'h0, 64'h0, 64'h0, 64'h0000_0000_8000_0000};
    localparam logic [NR*AW-1:0] RST_LENGTH = {64'h0, 64'h0, 64'h0, 64'h0000_0000_4000_0000};
    localparam logic [NR*4-1:0]  RST_ATTR   = {4'h0, 4'h0, 4'h0, 4'b0110};

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Main instance signals
    logic           cfg_req;
    logic           cfg_we;
    logic [CAW-1:0] cfg_addr;
    logic [AW-1:0]  cfg_wdata;
    logic           cfg_gnt;
    logic           cfg_rvalid;
    logic [AW-1:0]  cfg_rdata;
    logic           cfg_err;
    logic [EW-1:0]  cfg_epoch;
    logic           lookup_valid;
    logic [AW-1:0]  lookup_addr;
    logic           res_valid;
    logic           res_hit;
    logic           res_exec;
    logic           res_cached;
    logic           res_nonidem;

    // Three-rule instance signals
    logic           c3_req;
    logic           c3_we;
    logic [3:0]     c3_addr;
    logic [AW-1:0]  c3_wdata;
    logic           c3_gnt;
    logic           c3_rvalid;
    logic [AW-1:0]  c3_rdata;
    logic           c3_err;
    logic [EW-1:0]  c3_epoch;
    logic           c3_lookup_valid;
    logic [AW-1:0]  c3_lookup_addr;
    logic           c3_res_valid;
    logic           c3_res_hit;
    logic           c3_res_exec;
    logic           c3_res_cached;
    logic           c3_res_nonidem;

    int checks   = 0;
    int failures = 0;

    pma_region_cfg #(
        .NrRules    (NR),
        .AddrWidth  (AW),
        .EpochWidth (EW),
        .RstBase    (RST_BASE),
        .RstLength  (RST_LENGTH),
        .RstAttr    (RST_ATTR)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg_req_i      (cfg_req),
        .cfg_we_i       (cfg_we),
        .cfg_addr_i     (cfg_addr),
        .cfg_wdata_i    (cfg_wdata),
        .cfg_gnt_o      (cfg_gnt),
        .cfg_rvalid_o   (cfg_rvalid),
        .cfg_rdata_o    (cfg_rdata),
        .cfg_err_o      (cfg_err),
        .cfg_epoch_o    (cfg_epoch),
        .lookup_valid_i (lookup_valid),
        .lookup_addr_i  (lookup_addr),
        .res_valid_o    (res_valid),
        .res_hit_o      (res_hit),
        .res_exec_o     (res_exec),
        .res_cached_o   (res_cached),
        .res_nonidem_o  (res_nonidem)
    );

    pma_region_cfg #(
        .NrRules    (3),
        .AddrWidth  (AW),
        .EpochWidth (EW)
    ) dut3 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg_req_i      (c3_req),
        .cfg_we_i       (c3_we),
        .cfg_addr_i     (c3_addr),
        .cfg_wdata_i    (c3_wdata),
        .cfg_gnt_o      (c3_gnt),
        .cfg_rvalid_o   (c3_rvalid),
        .cfg_rdata_o    (c3_rdata),
        .cfg_err_o      (c3_err),
        .cfg_epoch_o    (c3_epoch),
        .lookup_valid_i (c3_lookup_valid),
        .lookup_addr_i  (c3_lookup_addr),
        .res_valid_o    (c3_res_valid),
        .res_hit_o      (c3_res_hit),
        .res_exec_o     (c3_res_exec),
        .res_cached_o   (c3_res_cached),
        .res_nonidem_o  (c3_res_nonidem)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of main-instance inputs from a falling edge and
    // checks the combinational grant. It returns at the next falling edge
    // with the inputs idled, so the registered responses of that cycle are
    // visible.
    task automatic applyStimulus(input logic req, input logic we, input logic [3:0] addr,
                                 input logic [63:0] wdata, input logic lv,
                                 input logic [63:0] la);
        cfg_req      = req;
        cfg_we       = we;
        cfg_addr     = addr;
        cfg_wdata    = wdata;
        lookup_valid = lv;
        lookup_addr  = la;
        #1;
        checkOutput("gnt", 64'(cfg_gnt), 64'(req));
        @(negedge clk);
        cfg_req      = 1'b0;
        cfg_we       = 1'b0;
        lookup_valid = 1'b0;
    endtask

    task automatic applyStimulus3(input logic we, input logic [3:0] addr,
                                  input logic [63:0] wdata);
        c3_req   = 1'b1;
        c3_we    = we;
        c3_addr  = addr;
        c3_wdata = wdata;
        #1;
        checkOutput("c3_gnt", 64'(c3_gnt), 64'd1);
        @(negedge clk);
        c3_req = 1'b0;
        c3_we  = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic hit, input logic ex,
                               input logic ca, input logic ni);
        checkOutput({tag, "_valid"},   64'(res_valid),   64'd1);
        checkOutput({tag, "_hit"},     64'(res_hit),     64'(hit));
        checkOutput({tag, "_exec"},    64'(res_exec),    64'(ex));
        checkOutput({tag, "_cached"},  64'(res_cached),  64'(ca));
        checkOutput({tag, "_nonidem"}, 64'(res_nonidem), 64'(ni));
    endtask

    task automatic checkResp(input string tag, input logic err, input logic [63:0] rdata,
                             input logic [7:0] epoch);
        checkOutput({tag, "_rvalid"}, 64'(cfg_rvalid), 64'd1);
        checkOutput({tag, "_err"},    64'(cfg_err),    64'(err));
        checkOutput({tag, "_rdata"},  cfg_rdata,       rdata);
        checkOutput({tag, "_epoch"},  64'(cfg_epoch),  64'(epoch));
    endtask

    initial begin
        rst_n           = 1'b0;
        cfg_req         = 1'b0;
        cfg_we          = 1'b0;
        cfg_addr        = '0;
        cfg_wdata       = '0;
        lookup_valid    = 1'b0;
        lookup_addr     = '0;
        c3_req          = 1'b0;
        c3_we           = 1'b0;
        c3_addr         = '0;
        c3_wdata        = '0;
        c3_lookup_valid = 1'b0;
        c3_lookup_addr  = '0;

        // Reset state
        #2;
        checkOutput("rst_rvalid",    64'(cfg_rvalid),  64'd0);
        checkOutput("rst_err",       64'(cfg_err),     64'd0);
        checkOutput("rst_rdata",     cfg_rdata,        64'd0);
        checkOutput("rst_epoch",     64'(cfg_epoch),   64'd0);
        checkOutput("rst_res_valid", 64'(res_valid),   64'd0);
        checkOutput("rst_res_hit",   64'(res_hit),     64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_rvalid",    64'(cfg_rvalid), 64'd0);
        checkOutput("post_rst_res_valid", 64'(res_valid),  64'd0);

        // Preset rule 0: hit inside, miss at its exclusive end
        applyStimulus(1'b0, 1'b0, 4'h0, 64'h0, 1'b1, 64'h0000_0000_8000_1000);
        checkResult("lk_8000_1000", 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 64'h0, 1'b1, 64'h0000_0000_C000_0000);
        checkResult("lk_C000_0000", 1'b0, 1'b0, 1'b0, 1'b0);

        // Program rule 1: base, length, attr nonidem
        applyStimulus(1'b1, 1'b1, 4'b0100, 64'h1_0000, 1'b0, 64'h0);
        checkResp("wr_r1_base", 1'b0, 64'h0, 8'd1);
        applyStimulus(1'b1, 1'b1, 4'b0101, 64'h1_0000, 1'b0, 64'h0);
        checkResp("wr_r1_len", 1'b0, 64'h0, 8'd2);
        applyStimulus(1'b1, 1'b1, 4'b0110, 64'h1, 1'b0, 64'h0);
        checkResp("wr_r1_attr", 1'b0, 64'h0, 8'd3);
        applyStimulus(1'b0, 1'b0, 4'h0, 64'h0, 1'b1, 64'h1_FFFF);
        checkOutput("idle_rvalid", 64'(cfg_rvalid), 64'd0);
        checkResult("lk_1FFFF", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 64'h0, 1'b0, 64'h0);
        checkOutput("hold_res_valid",   64'(res_valid),   64'd0);
        checkOutput("hold_res_hit",     64'(res_hit),     64'd1);
        checkOutput("hold_res_nonidem", 64'(res_nonidem), 64'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 64'h0, 1'b1, 64'h2_0000);
        checkResult("lk_20000", 1'b0, 1'b0, 1'b0, 1'b0);

        // Lock rule 2, then writes to it fail and reads still work
        applyStimulus(1'b1, 1'b1, 4'b1010, 64'hC, 1'b0, 64'h0);
        checkResp("wr_r2_lock", 1'b0, 64'h0, 8'd4);
        applyStimulus(1'b1, 1'b1, 4'b1000, 64'h5000, 1'b0, 64'h0);
        checkResp("wr_r2_base_locked", 1'b1, 64'h0, 8'd4);
        applyStimulus(1'b1, 1'b0, 4'b1000, 64'h0, 1'b0, 64'h0);
        checkResp("rd_r2_base", 1'b0, 64'h0, 8'd4);
        applyStimulus(1'b1, 1'b1, 4'b1010, 64'h0, 1'b0, 64'h0);
        checkResp("wr_r2_unlock", 1'b1, 64'h0, 8'd4);
        applyStimulus(1'b1, 1'b0, 4'b1010, 64'h0, 1'b0, 64'h0);
        checkResp("rd_r2_attr", 1'b0, 64'hC, 8'd4);

        // Rule 3 at the top of the address space, read back right after write
        applyStimulus(1'b1, 1'b1, 4'b1100, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 64'h0);
        checkResp("wr_r3_base", 1'b0, 64'h0, 8'd5);
        applyStimulus(1'b1, 1'b0, 4'b1100, 64'h0, 1'b0, 64'h0);
        checkResp("rd_r3_base", 1'b0, 64'hFFFF_FFFF_FFFF_F000, 8'd5);
        applyStimulus(1'b1, 1'b1, 4'b1101, 64'h1000, 1'b0, 64'h0);
        checkResp("wr_r3_len", 1'b0, 64'h0, 8'd6);
        applyStimulus(1'b0, 1'b0, 4'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        checkResult("lk_top", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reserved field
        applyStimulus(1'b1, 1'b1, 4'b0011, 64'h1234, 1'b0, 64'h0);
        checkResp("wr_field3", 1'b1, 64'h0, 8'd6);

        // Out-of-range rule index on the three-rule instance
        applyStimulus3(1'b0, 4'b1100, 64'h0);
        checkOutput("c3_idx3_rvalid", 64'(c3_rvalid), 64'd1);
        checkOutput("c3_idx3_err",    64'(c3_err),    64'd1);
        checkOutput("c3_idx3_rdata",  c3_rdata,       64'd0);
        applyStimulus3(1'b1, 4'b1101, 64'h10);
        checkOutput("c3_idx3_wr_err",   64'(c3_err),   64'd1);
        checkOutput("c3_idx3_wr_epoch", 64'(c3_epoch), 64'd0);
        applyStimulus3(1'b1, 4'b1000, 64'h7000);
        checkOutput("c3_r2_wr_err",   64'(c3_err),   64'd0);
        checkOutput("c3_r2_wr_epoch", 64'(c3_epoch), 64'd1);

        // Write and lookup in the same cycle: lookup sees the old table
        applyStimulus(1'b1, 1'b1, 4'b0001, 64'h0, 1'b1, 64'h0000_0000_8000_0000);
        checkResult("lk_same_cycle", 1'b1, 1'b1, 1'b1, 1'b0);
        checkResp("wr_r0_len0", 1'b0, 64'h0, 8'd7);
        applyStimulus(1'b0, 1'b0, 4'h0, 64'h0, 1'b1, 64'h0000_0000_8000_0000);
        checkResult("lk_after_disable", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with a lookup and a config read in flight
        cfg_req      = 1'b1;
        cfg_we       = 1'b0;
        cfg_addr     = 4'b0100;
        lookup_valid = 1'b1;
        lookup_addr  = 64'h1_0000;
        @(posedge clk);
        #1;
        checkOutput("inflight_rvalid",    64'(cfg_rvalid), 64'd1);
        checkOutput("inflight_res_valid", 64'(res_valid),  64'd1);
        rst_n        = 1'b0;
        cfg_req      = 1'b0;
        lookup_valid = 1'b0;
        #1;
        checkOutput("midrst_rvalid",    64'(cfg_rvalid),  64'd0);
        checkOutput("midrst_rdata",     cfg_rdata,        64'd0);
        checkOutput("midrst_res_valid", 64'(res_valid),   64'd0);
        checkOutput("midrst_res_hit",   64'(res_hit),     64'd0);
        checkOutput("midrst_epoch",     64'(cfg_epoch),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rerst_rvalid",    64'(cfg_rvalid), 64'd0);
        checkOutput("rerst_res_valid", 64'(res_valid),  64'd0);

        // Table back at its parameter values, lock on rule 2 gone
        applyStimulus(1'b1, 1'b0, 4'b0001, 64'h0, 1'b0, 64'h0);
        checkResp("rerst_rd_r0_len", 1'b0, 64'h4000_0000, 8'd0);
        applyStimulus(1'b1, 1'b0, 4'b0100, 64'h0, 1'b0, 64'h0);
        checkResp("rerst_rd_r1_base", 1'b0, 64'h0, 8'd0);
        applyStimulus(1'b1, 1'b0, 4'b1010, 64'h0, 1'b0, 64'h0);
        checkResp("rerst_rd_r2_attr", 1'b0, 64'h0, 8'd0);
        applyStimulus(1'b1, 1'b0, 4'b1100, 64'h0, 1'b0, 64'h0);
        checkResp("rerst_rd_r3_base", 1'b0, 64'h0, 8'd0);
        applyStimulus(1'b1, 1'b1, 4'b1000, 64'h5000, 1'b1, 64'h0000_0000_8000_1000);
        checkResp("rerst_wr_r2_base", 1'b0, 64'h0, 8'd1);
        checkResult("rerst_lk_8000_1000", 1'b1, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
